csa_feeder: RTL and testbench
=============================

CSA_FEEDER -- requirements
Module: csa_feeder

Interface
REQ-001 Parameter W, default 26, operand/result width; it SHALL match the width of the five-operand CSA summer.
REQ-002 Parameter TAG_W, default 4, width of the user tag carried with each operand bundle.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  an operand bundle is offered.
REQ-006 in_ready  output  1  the input FIFO can accept a bundle this cycle.
REQ-007 in_a0, in_a1, in_a2, in_b0, in_b1  input  W each  the five operands.
REQ-008 in_tag  input  TAG_W  tag returned with the sum.
REQ-009 csa_a0, csa_a1, csa_a2  output  W each  first-level operands to the summer; each SHALL be registered.
REQ-010 csa_b0, csa_b1  output  W each  late operands to the summer; each SHALL be registered.
REQ-011 csa_result  input  W  registered sum from the summer.
REQ-012 out_valid  output  1  out_sum and out_tag hold a completed result.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out_sum  output  W  (a0+a1+a2+b0+b1) mod 2^W.
REQ-015 out_tag  output  TAG_W  tag of the bundle that produced out_sum.
REQ-016 busy  output  1  high while any bundle is in the input FIFO, in flight, or in the output buffer.

Function
REQ-017 The input FIFO SHALL hold 2 entries; in_ready = (count < 2); a bundle is accepted on an edge where in_valid and in_ready are both high.
REQ-018 An entry accepted at edge H SHALL NOT be issued before edge H+1; the FIFO SHALL have no combinational bypass.
REQ-019 The block SHALL issue the FIFO head at edge E when the FIFO is not empty and credits > 0; credits = 4 - (in-flight count + output-buffer count).
REQ-020 At issue edge E: csa_a0..a2 <= head A operands, and the head B operands and tag SHALL be latched into stage p0.
REQ-021 At E+1: csa_b0, csa_b1 <= the p0 B operands; the tag SHALL advance to p1.
REQ-022 At E+2 the tag SHALL advance to p2; the summer loads csa_result at this edge.
REQ-023 At E+3, {csa_result, p2 tag} SHALL be written into the output buffer.
REQ-024 When no issue occurs, csa_a* and csa_b* SHALL hold their last values; the valid bits of p0, p1 and p2 SHALL mark stage occupancy.
REQ-025 Throughput SHALL be 1 bundle per cycle when unstalled; issues in consecutive cycles SHALL NOT corrupt the pairing of B operands with their A operands.
REQ-026 The output buffer SHALL be a 4-entry FIFO; out_valid = not empty; an entry pops on an edge where out_valid and out_ready are both high.
REQ-027 A simultaneous push and pop of the output buffer SHALL keep its count unchanged; credits SHALL make overflow impossible.
REQ-028 A simultaneous input accept and issue SHALL keep the input FIFO count unchanged.
REQ-029 Order SHALL be preserved: results are returned in acceptance order.
REQ-030 Sum wrap-around SHALL be modulo 2^W, with no saturation and no carry-out.
REQ-031 busy SHALL be the OR of: input FIFO not empty, any p-stage valid, output buffer not empty.

Reset
REQ-032 While rst_n=0 at an edge, the following SHALL be cleared: both FIFOs, all p-stage valids and tags, and csa_a*, csa_b*, out_sum, out_tag.
REQ-033 After reset: out_valid=0, busy=0, in_ready=1.
REQ-034 A reset asserted mid-operation SHALL discard every queued and in-flight bundle; no result from before the reset SHALL appear afterwards.

Verification
REQ-035 Accept {1,2,3,4,5}, tag 3, at edge H with out_ready=1 -> out_valid first high after edge H+4, out_sum=15, out_tag=3.
REQ-036 Operands all 0x3FFFFFF -> out_sum=0x3FFFFFB.
REQ-037 Stream 8 bundles back-to-back with sums 10..17 and out_ready=1 -> 8 results on 8 consecutive cycles, in order, tags matching.
REQ-038 Hold out_ready=0 and offer 7 bundles -> 6 are accepted (4 in the output buffer, 2 in the input FIFO) and in_ready=0; raise out_ready -> all 6 drain in order.
REQ-039 Alternate issue and idle cycles with distinct B values -> each out_sum matches its own bundle, with no B mismatch.
REQ-040 Assert rst_n=0 for 1 cycle with 3 bundles in flight -> out_valid=0 and busy=0 on the next cycle, and no stale result ever appears.

Source files
------------

// File: rtl/csa_feeder.sv
// csa_feeder: buffers operand bundles and feeds them to an external
// registered five-operand CSA summer. The A operands go out on the issue
// edge and the B operands one edge later. Results are returned in
// acceptance order through a credit-limited output buffer.
module csa_feeder #(
    parameter int W     = 26,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a0,
    input  logic [W-1:0]     in_a1,
    input  logic [W-1:0]     in_a2,
    input  logic [W-1:0]     in_b0,
    input  logic [W-1:0]     in_b1,
    input  logic [TAG_W-1:0] in_tag,
    output logic [W-1:0]     csa_a0,
    output logic [W-1:0]     csa_a1,
    output logic [W-1:0]     csa_a2,
    output logic [W-1:0]     csa_b0,
    output logic [W-1:0]     csa_b1,
    input  logic [W-1:0]     csa_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef struct packed {
        logic [W-1:0]     a0;
        logic [W-1:0]     a1;
        logic [W-1:0]     a2;
        logic [W-1:0]     b0;
        logic [W-1:0]     b1;
        logic [TAG_W-1:0] tag;
    } bundle_t;

    // input FIFO (2 entries)
    bundle_t    fifo_mem [2];
    logic       fifo_wr_ptr;
    logic       fifo_rd_ptr;
    logic [1:0] fifo_cnt;
    bundle_t    in_bundle;
    bundle_t    head;

    // delay stages between issue and result capture
    logic [W-1:0]     p0_b0;
    logic [W-1:0]     p0_b1;
    logic [TAG_W-1:0] p0_tag;
    logic [TAG_W-1:0] p1_tag;
    logic [TAG_W-1:0] p2_tag;
    logic             p0_vld;
    logic             p1_vld;
    logic             p2_vld;

    // output buffer (4 entries)
    logic [W-1:0]     ob_sum [4];
    logic [TAG_W-1:0] ob_tag [4];
    logic [1:0]       ob_wr_ptr;
    logic [1:0]       ob_rd_ptr;
    logic [2:0]       ob_cnt;

    logic       accept;
    logic       issue;
    logic       push;
    logic       pop;
    logic [2:0] occupancy;

    // handshakes, issue decision and output read-out
    always_comb begin
        in_bundle.a0  = in_a0;
        in_bundle.a1  = in_a1;
        in_bundle.a2  = in_a2;
        in_bundle.b0  = in_b0;
        in_bundle.b1  = in_b1;
        in_bundle.tag = in_tag;
        in_ready      = (fifo_cnt != 2'd2);
        accept        = in_valid & in_ready;
        head          = fifo_mem[fifo_rd_ptr];
        push          = p2_vld;
        out_valid     = (ob_cnt != 3'd0);
        pop           = out_valid & out_ready;
        // A slot freed by this edge's pop is counted as available, so a
        // full pipeline with a draining consumer still issues every cycle.
        occupancy     = 3'(p0_vld) + 3'(p1_vld) + 3'(p2_vld) + ob_cnt - 3'(pop);
        issue         = (fifo_cnt != 2'd0) && (occupancy < 3'd4);
        out_sum       = ob_sum[ob_rd_ptr];
        out_tag       = ob_tag[ob_rd_ptr];
        busy          = (fifo_cnt != 2'd0) | p0_vld | p1_vld | p2_vld | out_valid;
    end

    // input FIFO storage, pointers and count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem    <= '{default: '0};
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (accept) begin
                fifo_mem[fifo_wr_ptr] <= in_bundle;
                fifo_wr_ptr           <= ~fifo_wr_ptr;
            end
            if (issue) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({accept, issue})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // issue stage: A operands to the summer, B operands and tag into p0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csa_a0 <= '0;
            csa_a1 <= '0;
            csa_a2 <= '0;
            p0_b0  <= '0;
            p0_b1  <= '0;
            p0_tag <= '0;
            p0_vld <= 1'b0;
        end else begin
            p0_vld <= issue;
            if (issue) begin
                csa_a0 <= head.a0;
                csa_a1 <= head.a1;
                csa_a2 <= head.a2;
                p0_b0  <= head.b0;
                p0_b1  <= head.b1;
                p0_tag <= head.tag;
            end
        end
    end

    // late operands to the summer; tag follows the summer latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csa_b0 <= '0;
            csa_b1 <= '0;
            p1_tag <= '0;
            p2_tag <= '0;
            p1_vld <= 1'b0;
            p2_vld <= 1'b0;
        end else begin
            p1_vld <= p0_vld;
            p2_vld <= p1_vld;
            if (p0_vld) begin
                csa_b0 <= p0_b0;
                csa_b1 <= p0_b1;
                p1_tag <= p0_tag;
            end
            if (p1_vld) begin
                p2_tag <= p1_tag;
            end
        end
    end

    // output buffer: capture summer result with its tag, pop on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ob_sum    <= '{default: '0};
            ob_tag    <= '{default: '0};
            ob_wr_ptr <= '0;
            ob_rd_ptr <= '0;
            ob_cnt    <= '0;
        end else begin
            if (push) begin
                ob_sum[ob_wr_ptr] <= csa_result;
                ob_tag[ob_wr_ptr] <= p2_tag;
                ob_wr_ptr         <= ob_wr_ptr + 2'd1;
            end
            if (pop) begin
                ob_rd_ptr <= ob_rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   ob_cnt <= ob_cnt + 3'd1;
                2'b01:   ob_cnt <= ob_cnt - 3'd1;
                default: ob_cnt <= ob_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_feeder.sv
// tb_csa_feeder: randomized bench for csa_feeder with a behavioural model
// of the two-stage summer and a sum/tag scoreboard in acceptance order.
module tb_csa_feeder;

    localparam int W     = 26;
    localparam int TAG_W = 4;

    typedef struct {
        bit               gap;
        logic [W-1:0]     a0, a1, a2, b0, b1;
        logic [TAG_W-1:0] tag;
    } stim_t;

    typedef struct {
        logic [W-1:0]     sum;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a0 = '0, in_a1 = '0, in_a2 = '0, in_b0 = '0, in_b1 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [W-1:0]     csa_a0, csa_a1, csa_a2, csa_b0, csa_b1;
    logic [W-1:0]     csa_result = '0;
    logic [W-1:0]     sum_s1 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_sum;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int    cyc = 0;
    int    pass_cnt = 0;
    int    total_cnt = 0;
    stim_t pend[$];
    res_t  exp_q[$];
    res_t  obs_q[$];
    int    acc_cyc[$];

    csa_feeder #(.W(W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2), .in_b0(in_b0), .in_b1(in_b1),
        .in_tag(in_tag),
        .csa_a0(csa_a0), .csa_a1(csa_a1), .csa_a2(csa_a2),
        .csa_b0(csa_b0), .csa_b1(csa_b1),
        .csa_result(csa_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // summer: first level adds the A operands, second adds the late B operands
    always @(posedge clk) begin
        sum_s1     <= csa_a0 + csa_a1 + csa_a2;
        csa_result <= sum_s1 + csa_b0 + csa_b1;
    end

    function automatic logic [W-1:0] rnd_w();
        logic [31:0] r;
        r = $urandom;
        return r[W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] rnd_tag();
        logic [31:0] r;
        r = $urandom;
        return r[TAG_W-1:0];
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.gap = 1'b0;
        s.a0 = rnd_w(); s.a1 = rnd_w(); s.a2 = rnd_w();
        s.b0 = rnd_w(); s.b1 = rnd_w();
        s.tag = rnd_tag();
        return s;
    endfunction

    function automatic stim_t gap_stim();
        stim_t s;
        s = rnd_stim();
        s.gap = 1'b1;
        return s;
    endfunction

    // reference: plain wide addition reduced modulo 2^W
    function automatic res_t model(input stim_t s);
        res_t r;
        logic [63:0] t;
        t = 64'(s.a0) + 64'(s.a1) + 64'(s.a2) + 64'(s.b0) + 64'(s.b1);
        r.sum = t[W-1:0];
        r.tag = s.tag;
        r.cyc = 0;
        return r;
    endfunction

    function automatic void clear_queues();
        exp_q.delete();
        obs_q.delete();
        acc_cyc.delete();
    endfunction

    // drive one cycle at the falling edge, record accepts and pops
    task automatic one_cycle(input bit ordy);
        stim_t d;
        res_t  r;
        @(negedge clk);
        out_ready = ordy;
        in_valid  = 1'b0;
        in_a0 = rnd_w(); in_a1 = rnd_w(); in_a2 = rnd_w();
        in_b0 = rnd_w(); in_b1 = rnd_w(); in_tag = rnd_tag();
        if (pend.size() > 0) begin
            if (pend[0].gap) begin
                d = pend.pop_front();
            end else begin
                in_valid = 1'b1;
                in_a0 = pend[0].a0; in_a1 = pend[0].a1; in_a2 = pend[0].a2;
                in_b0 = pend[0].b0; in_b1 = pend[0].b1; in_tag = pend[0].tag;
            end
        end
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(pend[0]));
            acc_cyc.push_back(cyc + 1);
            d = pend.pop_front();
        end
        if (out_valid && out_ready) begin
            r.sum = out_sum;
            r.tag = out_tag;
            r.cyc = cyc;
            obs_q.push_back(r);
        end
    endtask

    task automatic drain(input int n, input int limit);
        int guard;
        guard = 0;
        while ((pend.size() > 0 || obs_q.size() < n) && guard < limit) begin
            one_cycle(1'b1);
            guard++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (csa_a0 !== '0) $display("FAIL rst_csa_a0: got %0h want 0", csa_a0); else pass_cnt++;
        total_cnt++; if (csa_b1 !== '0) $display("FAIL rst_csa_b1: got %0h want 0", csa_b1); else pass_cnt++;
        total_cnt++; if (out_sum !== '0 || out_tag !== '0)
            $display("FAIL rst_out: got %0h/%0h want 0/0", out_sum, out_tag); else pass_cnt++;
        rst_n = 1'b1;
        clear_queues();
    endtask

    task automatic test_single();
        stim_t s;
        clear_queues();
        s.gap = 1'b0;
        s.a0 = W'(1); s.a1 = W'(2); s.a2 = W'(3); s.b0 = W'(4); s.b1 = W'(5);
        s.tag = TAG_W'(3);
        pend.push_back(s);
        drain(1, 20);
        total_cnt++;
        if (obs_q.size() < 1) begin
            $display("FAIL single_timeout: got 0 results want 1");
        end else if (obs_q[0].cyc != acc_cyc[0] + 4) begin
            $display("FAIL single_latency: got %0d want %0d", obs_q[0].cyc - acc_cyc[0], 4);
        end else pass_cnt++;
        if (obs_q.size() >= 1) begin
            total_cnt++; if (obs_q[0].sum !== W'(15)) $display("FAIL single_sum: got %0d want 15", obs_q[0].sum); else pass_cnt++;
            total_cnt++; if (obs_q[0].tag !== TAG_W'(3)) $display("FAIL single_tag: got %0d want 3", obs_q[0].tag); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        stim_t s;
        clear_queues();
        s.gap = 1'b0;
        s.a0 = '1; s.a1 = '1; s.a2 = '1; s.b0 = '1; s.b1 = '1;
        s.tag = rnd_tag();
        pend.push_back(s);
        drain(1, 20);
        total_cnt++;
        if (obs_q.size() < 1) $display("FAIL wrap_timeout: got 0 results want 1");
        else if (obs_q[0].sum !== 26'h3FFFFFB) $display("FAIL wrap_sum: got %0h want 3fffffb", obs_q[0].sum);
        else pass_cnt++;
        if (obs_q.size() >= 1) begin
            total_cnt++; if (obs_q[0].tag !== s.tag) $display("FAIL wrap_tag: got %0d want %0d", obs_q[0].tag, s.tag); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            s = rnd_stim();
            s.b1 = W'(10 + i) - s.a0 - s.a1 - s.a2 - s.b0;
            pend.push_back(s);
        end
        drain(8, 40);
        total_cnt++;
        if (acc_cyc.size() != 8 || acc_cyc[7] - acc_cyc[0] != 7)
            $display("FAIL b2b_accept: got %0d accepts want 8 consecutive", acc_cyc.size());
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (i >= obs_q.size()) $display("FAIL b2b_missing[%0d]: got none want result", i);
            else if (obs_q[i].sum !== W'(10 + i) || obs_q[i].tag !== exp_q[i].tag)
                $display("FAIL b2b_res[%0d]: got %0d/%0d want %0d/%0d", i, obs_q[i].sum, obs_q[i].tag, 10 + i, exp_q[i].tag);
            else if (obs_q[i].cyc - obs_q[0].cyc != i)
                $display("FAIL b2b_gap[%0d]: got offset %0d want %0d", i, obs_q[i].cyc - obs_q[0].cyc, i);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        clear_queues();
        for (int i = 0; i < 7; i++) pend.push_back(rnd_stim());
        repeat (15) one_cycle(1'b0);
        total_cnt++; if (exp_q.size() != 6) $display("FAIL bp_accepted: got %0d want 6", exp_q.size()); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL bp_status: got %0b/%0b want 1/1", out_valid, busy); else pass_cnt++;
        total_cnt++; if (obs_q.size() != 0) $display("FAIL bp_early_pop: got %0d want 0", obs_q.size()); else pass_cnt++;
        pend.delete();
        drain(6, 30);
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (i >= obs_q.size()) $display("FAIL bp_missing[%0d]: got none want result", i);
            else if (obs_q[i].sum !== exp_q[i].sum || obs_q[i].tag !== exp_q[i].tag)
                $display("FAIL bp_res[%0d]: got %0h/%0h want %0h/%0h", i, obs_q[i].sum, obs_q[i].tag, exp_q[i].sum, exp_q[i].tag);
            else pass_cnt++;
        end
    endtask

    task automatic test_alternate();
        clear_queues();
        for (int i = 0; i < 8; i++) begin
            pend.push_back(rnd_stim());
            pend.push_back(gap_stim());
        end
        drain(8, 60);
        repeat (6) one_cycle(1'b1);
        total_cnt++; if (obs_q.size() != 8) $display("FAIL alt_count: got %0d want 8", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (i >= obs_q.size()) $display("FAIL alt_missing[%0d]: got none want result", i);
            else if (obs_q[i].sum !== exp_q[i].sum || obs_q[i].tag !== exp_q[i].tag)
                $display("FAIL alt_res[%0d]: got %0h/%0h want %0h/%0h", i, obs_q[i].sum, obs_q[i].tag, exp_q[i].sum, exp_q[i].tag);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        for (int i = 0; i < 3; i++) pend.push_back(rnd_stim());
        repeat (4) one_cycle(1'b1);
        @(negedge clk);
        #1;
        total_cnt++; if (busy !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL mid_pre: got busy %0b valid %0b want 1/0", busy, out_valid); else pass_cnt++;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %0b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1 || csa_b0 !== '0)
            $display("FAIL mid_clear: got ready %0b b0 %0h want 1/0", in_ready, csa_b0); else pass_cnt++;
        clear_queues();
        repeat (12) one_cycle(1'b1);
        total_cnt++; if (obs_q.size() != 0) $display("FAIL mid_stale: got %0d results want 0", obs_q.size()); else pass_cnt++;
        clear_queues();
        pend.push_back(rnd_stim());
        drain(1, 20);
        total_cnt++;
        if (obs_q.size() < 1) $display("FAIL mid_fresh_timeout: got 0 results want 1");
        else if (obs_q[0].sum !== exp_q[0].sum || obs_q[0].tag !== exp_q[0].tag)
            $display("FAIL mid_fresh: got %0h/%0h want %0h/%0h", obs_q[0].sum, obs_q[0].tag, exp_q[0].sum, exp_q[0].tag);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int guard;
        clear_queues();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) pend.push_back(gap_stim());
            pend.push_back(rnd_stim());
        end
        guard = 0;
        while (pend.size() > 0 && guard < 2000) begin
            one_cycle($urandom_range(0, 3) != 0);
            guard++;
        end
        drain(60, 60);
        repeat (6) one_cycle(1'b1);
        total_cnt++; if (obs_q.size() != 60) $display("FAIL rnd_count: got %0d want 60", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 60; i++) begin
            total_cnt++;
            if (i >= obs_q.size()) $display("FAIL rnd_missing[%0d]: got none want result", i);
            else if (obs_q[i].sum !== exp_q[i].sum || obs_q[i].tag !== exp_q[i].tag)
                $display("FAIL rnd_res[%0d]: got %0h/%0h want %0h/%0h", i, obs_q[i].sum, obs_q[i].tag, exp_q[i].sum, exp_q[i].tag);
            else pass_cnt++;
        end
        total_cnt++; if (busy !== 1'b0) $display("FAIL rnd_idle_busy: got %0b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_alternate();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
